// File: rtl/mem_io_responder.sv
// Memory-side responder for the core's byte bus: 128 KB RAM plus an I/O window
// holding UART TX/RX FIFOs, a free-running cycle counter and the stop flag.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TXQ_LOG        = 3,
  parameter int RXQ_LOG        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        tx_overflow
);
  localparam int TXQ_DEPTH = 1 << TXQ_LOG;
  localparam int RXQ_DEPTH = 1 << RXQ_LOG;
  localparam logic [TXQ_LOG:0] TX_HIWAT = (TXQ_LOG + 1)'(TXQ_DEPTH - 1);

  logic [7:0] ram    [2**RAM_ADDR_WIDTH];
  logic [7:0] tx_buf [TXQ_DEPTH];
  logic [7:0] rx_buf [RXQ_DEPTH];

  logic [TXQ_LOG:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_cnt_d;
  logic [RXQ_LOG:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [31:0]      cnt_q, cnt_d, cnt_latch_q, cnt_latch_d;
  logic             stop_req_q, stop_req_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             ibf_q, ibf_d;
  logic [7:0]       io_rd_q, io_rd_d;
  logic             sel_ram_q, sel_ram_d;
  logic [7:0]       ram_rd_q;

  logic                      is_io;
  logic [2:0]                io_off;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      wr_req, rd_req, ram_wr, ram_rd;
  logic                      tx_empty, tx_full, rx_empty, rx_full;
  logic                      tx_push, tx_push_ok, tx_pop, rx_push, rx_pop;
  logic [7:0]                tx_push_data;
  logic                      unused_addr_bits;

  assign is_io            = (mem_a[17:16] == 2'b11);
  assign io_off           = mem_a[2:0];
  assign ram_addr         = mem_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^mem_a;

  assign wr_req = rdy_in & mem_wr;
  assign rd_req = rdy_in & ~mem_wr;
  assign ram_wr = wr_req & ~is_io;
  assign ram_rd = rd_req & ~is_io;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TXQ_LOG] != tx_rd_q[TXQ_LOG]) &&
                    (tx_wr_q[TXQ_LOG-1:0] == tx_rd_q[TXQ_LOG-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RXQ_LOG] != rx_rd_q[RXQ_LOG]) &&
                    (rx_wr_q[RXQ_LOG-1:0] == rx_rd_q[RXQ_LOG-1:0]);

  // Host handshakes are masked while frozen so no byte is lost or duplicated.
  assign tx_valid = rdy_in & ~tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_buf[tx_rd_q[TXQ_LOG-1:0]];
  assign rx_ready = rdy_in & ~rx_full;

  assign mem_din        = sel_ram_q ? ram_rd_q : io_rd_q;
  assign io_buffer_full = ibf_q;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

  always_comb begin
    tx_pop       = tx_valid & tx_ready;
    tx_push      = wr_req & is_io &
                   (((io_off == 3'd0) & (mem_dout != 8'h00)) | (io_off == 3'd4));
    tx_push_data = (io_off == 3'd4) ? 8'h00 : mem_dout;
    tx_push_ok   = tx_push & (~tx_full | tx_pop);
    tx_wr_d      = tx_wr_q + {{TXQ_LOG{1'b0}}, tx_push_ok};
    tx_rd_d      = tx_rd_q + {{TXQ_LOG{1'b0}}, tx_pop};
    tx_cnt_d     = tx_wr_d - tx_rd_d;
    ibf_d        = rdy_in ? (tx_cnt_d >= TX_HIWAT) : ibf_q;
    ovf_d        = ovf_q | (tx_push & ~tx_push_ok);
    stop_req_d   = stop_req_q | (wr_req & is_io & (io_off == 3'd4));
    done_d       = done_q | (rdy_in & stop_req_q & tx_empty);

    rx_push = rx_valid & rx_ready;
    rx_pop  = rd_req & is_io & (io_off == 3'd0) & ~rx_empty;
    rx_wr_d = rx_wr_q + {{RXQ_LOG{1'b0}}, rx_push};
    rx_rd_d = rx_rd_q + {{RXQ_LOG{1'b0}}, rx_pop};

    cnt_d       = rdy_in ? cnt_q + 32'd1 : cnt_q;
    cnt_latch_d = cnt_latch_q;
    io_rd_d     = io_rd_q;
    sel_ram_d   = sel_ram_q;
    if (rd_req) begin
      sel_ram_d = ~is_io;
      case (io_off)
        3'd0:    io_rd_d = rx_empty ? 8'h00 : rx_buf[rx_rd_q[RXQ_LOG-1:0]];
        3'd4:    io_rd_d = cnt_q[7:0];
        3'd5:    io_rd_d = cnt_latch_q[15:8];
        3'd6:    io_rd_d = cnt_latch_q[23:16];
        3'd7:    io_rd_d = cnt_latch_q[31:24];
        default: io_rd_d = 8'h00;
      endcase
      // Low byte read freezes the upper bytes for a coherent multi-byte read.
      if (is_io && (io_off == 3'd4)) cnt_latch_d = cnt_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      cnt_q       <= '0;
      cnt_latch_q <= '0;
      stop_req_q  <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ibf_q       <= 1'b0;
      io_rd_q     <= 8'h00;
      sel_ram_q   <= 1'b0;
    end else begin
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      cnt_q       <= cnt_d;
      cnt_latch_q <= cnt_latch_d;
      stop_req_q  <= stop_req_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      ibf_q       <= ibf_d;
      io_rd_q     <= io_rd_d;
      sel_ram_q   <= sel_ram_d;
    end
  end

  // Storage arrays: plain enabled writes, no reset, so they map onto RAM blocks.
  always_ff @(posedge clk_in) begin
    if (ram_wr)     ram[ram_addr] <= mem_dout;
    if (ram_rd)     ram_rd_q <= ram[ram_addr];
    if (tx_push_ok) tx_buf[tx_wr_q[TXQ_LOG-1:0]] <= tx_push_data;
    if (rx_push)    rx_buf[rx_wr_q[RXQ_LOG-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: bus-vector table, directed UART/counter/stop
// sequences, and a randomized run against a queue-based reference model.
module tb_mem_io_responder;
  logic        clk = 1'b0;
  logic        rst, rdy, mem_wr, rx_valid, tx_ready;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, rx_data;
  logic [7:0]  mem_din, tx_data;
  logic        io_buffer_full, rx_ready, tx_valid, program_done, tx_overflow;

  mem_io_responder dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .program_done(program_done), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] txcap[$];

  // reference model state
  logic [7:0]  m_ram[int];
  logic [7:0]  m_tq[$];
  logic [7:0]  m_rq[$];
  logic [31:0] m_cnt, m_latch;
  logic [7:0]  m_din;
  logic        m_stop, m_done, m_ovf, m_ibf;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;
  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rdy && tx_valid && tx_ready) txcap.push_back(tx_data);
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr = wr; mem_a = a; mem_dout = d;
    tick();
    mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    txcap.delete();
  endtask

  task automatic rstep(input logic r, input logic txr, input logic rxv, input logic [7:0] rxd,
                       input logic wr, input logic [31:0] a, input logic [7:0] d);
    logic       io, pop, rxacc, push;
    logic [2:0] off;
    logic [7:0] pd;
    int         sz;
    rdy = r; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    mem_wr = wr; mem_a = a; mem_dout = d;
    @(negedge clk);
    if (r) begin
      check("rnd_tx_valid", tx_valid, m_tq.size() != 0);
      check("rnd_tx_data", tx_data, (m_tq.size() != 0) ? m_tq[0] : 8'h00);
      check("rnd_rx_ready", rx_ready, m_rq.size() < 8);
      io = (a[17:16] == 2'b11); off = a[2:0];
      pop = (m_tq.size() != 0) && txr;
      rxacc = rxv && (m_rq.size() < 8);
      sz = m_tq.size();
      m_done = m_done || (m_stop && sz == 0);
      push = 1'b0; pd = 8'h00;
      if (wr) begin
        if (!io) m_ram[int'(a[16:0])] = d;
        else if (off == 3'd0 && d != 8'h00) begin push = 1'b1; pd = d; end
        else if (off == 3'd4) begin push = 1'b1; pd = 8'h00; m_stop = 1'b1; end
      end else if (!io) begin
        m_din = m_ram[int'(a[16:0])];
      end else begin
        case (off)
          3'd0: m_din = (m_rq.size() != 0) ? m_rq.pop_front() : 8'h00;
          3'd4: begin m_din = m_cnt[7:0]; m_latch = m_cnt; end
          3'd5: m_din = m_latch[15:8];
          3'd6: m_din = m_latch[23:16];
          3'd7: m_din = m_latch[31:24];
          default: m_din = 8'h00;
        endcase
      end
      if (pop) void'(m_tq.pop_front());
      if (push) begin
        if (sz < 8 || pop) m_tq.push_back(pd);
        else m_ovf = 1'b1;
      end
      if (rxacc) m_rq.push_back(rxd);
      m_ibf = (m_tq.size() >= 7);
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    check("rnd_mem_din", mem_din, m_din);
    check("rnd_io_buffer_full", io_buffer_full, m_ibf);
    check("rnd_tx_overflow", tx_overflow, m_ovf);
    check("rnd_program_done", program_done, m_done);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  b0, b1, b2, b3;
    logic [16:0] slots[8];
    logic [31:0] a;
    logic [2:0]  off;
    int          kind;

    // Reset state
    do_reset();
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_io_buffer_full", io_buffer_full, 1'b0);
    check("rst_program_done", program_done, 1'b0);
    check("rst_tx_overflow", tx_overflow, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b1);

    // Bus vector table
    vt[0]  = '{wr: 1'b1, a: 32'h0000_0010, d: 8'hA5, exp: 8'h00};
    vt[1]  = '{wr: 1'b0, a: 32'h0000_0010, d: 8'h00, exp: 8'hA5};
    vt[2]  = '{wr: 1'b0, a: 32'h0002_0010, d: 8'h00, exp: 8'hA5};
    vt[3]  = '{wr: 1'b1, a: 32'h0001_0010, d: 8'hC3, exp: 8'hA5};
    vt[4]  = '{wr: 1'b0, a: 32'h0001_0010, d: 8'h00, exp: 8'hC3};
    vt[5]  = '{wr: 1'b0, a: 32'hFFF0_0010, d: 8'h00, exp: 8'hA5};
    vt[6]  = '{wr: 1'b1, a: 32'h0003_0002, d: 8'h77, exp: 8'hA5};
    vt[7]  = '{wr: 1'b0, a: 32'h0003_0001, d: 8'h00, exp: 8'h00};
    vt[8]  = '{wr: 1'b1, a: 32'h0000_0011, d: 8'h5A, exp: 8'h00};
    vt[9]  = '{wr: 1'b0, a: 32'h0000_0011, d: 8'h00, exp: 8'h5A};
    vt[10] = '{wr: 1'b0, a: 32'h0003_0000, d: 8'h00, exp: 8'h00};
    vt[11] = '{wr: 1'b0, a: 32'h0000_0010, d: 8'h00, exp: 8'hA5};
    for (int i = 0; i < 12; i++) begin
      bus(vt[i].wr, vt[i].a, vt[i].d);
      check($sformatf("vec%0d_mem_din", i), mem_din, vt[i].exp);
    end
    check("vec_no_tx_push", tx_valid, 1'b0);

    // UART out with zero filtering
    do_reset();
    tx_ready = 1'b1;
    bus(1'b1, 32'h0003_0000, 8'h48);
    bus(1'b1, 32'h0003_0000, 8'h00);
    bus(1'b1, 32'h0003_0000, 8'h69);
    repeat (4) tick();
    check("uart_count", txcap.size(), 2);
    check("uart_byte0", txcap[0], 8'h48);
    check("uart_byte1", txcap[1], 8'h69);

    // Back-pressure, overflow, push+pop while full
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      bus(1'b1, 32'h0003_0000, 8'(i));
      if (i == 6) check("bp_ibf_after6", io_buffer_full, 1'b0);
      if (i == 7) check("bp_ibf_after7", io_buffer_full, 1'b1);
      if (i == 8) check("bp_ovf_after8", tx_overflow, 1'b0);
      if (i == 9) check("bp_ovf_after9", tx_overflow, 1'b1);
    end
    tx_ready = 1'b1;
    bus(1'b1, 32'h0003_0000, 8'hEE);
    check("bp_full_pushpop_ibf", io_buffer_full, 1'b1);
    check("bp_ovf_sticky", tx_overflow, 1'b1);
    repeat (10) tick();
    check("bp_drain_count", txcap.size(), 9);
    check("bp_drain_first", txcap[0], 8'h01);
    check("bp_drain_8th", txcap[7], 8'h08);
    check("bp_drain_last", txcap[8], 8'hEE);
    check("bp_ibf_drained", io_buffer_full, 1'b0);

    // Cycle counter snapshot and freeze
    do_reset();
    repeat (100) tick();
    bus(1'b0, 32'h0003_0004, 8'h00); b0 = mem_din;
    bus(1'b0, 32'h0003_0005, 8'h00); b1 = mem_din;
    bus(1'b0, 32'h0003_0006, 8'h00); b2 = mem_din;
    bus(1'b0, 32'h0003_0007, 8'h00); b3 = mem_din;
    check("cnt_snapshot", {b3, b2, b1, b0}, 32'd100);
    rdy = 1'b0; mem_a = 32'h0000_0010;
    repeat (10) tick();
    check("freeze_mem_din_hold", mem_din, 8'h00);
    rdy = 1'b1;
    bus(1'b0, 32'h0003_0004, 8'h00);
    check("cnt_frozen", mem_din, 8'd104);

    // RX input, empty read, full FIFO
    do_reset();
    rx_valid = 1'b1; rx_data = 8'h31;
    tick();
    rx_valid = 1'b0;
    bus(1'b0, 32'h0003_0000, 8'h00);
    check("rx_read_byte", mem_din, 8'h31);
    bus(1'b0, 32'h0003_0000, 8'h00);
    check("rx_read_empty", mem_din, 8'h00);
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'(8'h40 + i);
      tick();
    end
    rx_valid = 1'b0;
    check("rx_full_ready", rx_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 32'h0003_0000, 8'h00);
      check($sformatf("rx_full_read%0d", i), mem_din, 8'(8'h40 + i));
    end
    check("rx_ready_after_drain", rx_ready, 1'b1);

    // Reset mid-operation flushes both FIFOs
    bus(1'b1, 32'h0003_0000, 8'h11);
    bus(1'b1, 32'h0003_0000, 8'h22);
    rx_valid = 1'b1; rx_data = 8'h99; tick(); rx_valid = 1'b0;
    do_reset();
    check("flush_tx_valid", tx_valid, 1'b0);
    bus(1'b0, 32'h0003_0000, 8'h00);
    check("flush_rx_empty", mem_din, 8'h00);

    // Stop request and program_done
    bus(1'b1, 32'h0003_0004, 8'h55);
    repeat (3) tick();
    check("stop_done_blocked", program_done, 1'b0);
    check("stop_tx_valid", tx_valid, 1'b1);
    check("stop_tx_data", tx_data, 8'h00);
    tx_ready = 1'b1;
    tick();
    check("stop_emitted_count", txcap.size(), 1);
    check("stop_emitted_zero", txcap[0], 8'h00);
    check("stop_done_not_yet", program_done, 1'b0);
    tick();
    check("stop_done_rises", program_done, 1'b1);
    bus(1'b1, 32'h0003_0000, 8'h41);
    check("stop_done_sticky", program_done, 1'b1);
    check("stop_post_write", tx_valid, 1'b1);

    // Randomized run against the reference model
    do_reset();
    m_tq.delete(); m_rq.delete();
    m_cnt = 32'd0; m_latch = 32'd0; m_din = 8'h00;
    m_stop = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_ibf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      slots[i] = 17'(i * 17'h2b57 + 3);
      rstep(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, {15'h0, slots[i]}, 8'($urandom));
    end
    for (int i = 0; i < 3000; i++) begin
      kind = $urandom_range(0, 99);
      a = $urandom;
      if (kind < 50) begin
        a[16:0] = slots[$urandom_range(0, 7)];
        if (a[16]) a[17] = 1'b0;
      end else begin
        a[17:16] = 2'b11;
        off = 3'($urandom_range(0, 7));
        if (kind >= 70 && off == 3'd4) off = 3'd0;
        if (kind >= 98 && i > 2500) off = 3'd4;
        a[2:0] = off;
      end
      rstep($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            8'($urandom), (kind >= 30 && kind < 50) || kind >= 70, a,
            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
